// File: rtl/sc_ifu.sv
// ---------------------------------------------------------------------------
// sc_ifu -- instruction fetch unit for a multi-cycle, single-issue core.
//
// The unit runs a three-state loop: IDLE (one cycle after reset), FETCH
// (request the word at pc and wait for an ack, with no timeout) and EXEC
// (present the captured instruction to the decoder until stall drops, then
// advance pc to the selected next PC).
//
// Optional feature (macro SC_IFU_MISALIGN_TRAP_EN):
//   defined   -> a next PC with non-zero low bits redirects pc to TRAP_PC and
//                pulses trap for the following cycle.
//   undefined -> the low two bits of the next PC are cleared; trap is 0.
//
// Parameters:
//   RESET_PC   PC loaded by reset.
//   TRAP_PC    PC loaded on a misaligned-target redirect.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   asynchronous, active-high reset
//   pcsource    in   next-PC select: 00 seq, 01 branch, 10 jr, 11 j/jal
//   ra          in   jr target register value
//   stall       in   hold the current instruction in EXEC
//   imem_req    out  instruction memory read request (high in FETCH)
//   imem_addr   out  fetch address (always pc)
//   imem_ack    in   read data valid this cycle
//   imem_rdata  in   instruction word
//   inst        out  registered instruction for the decoder
//   pc          out  registered PC of inst
//   pc4         out  pc + 4
//   inst_valid  out  inst is executing this cycle (high in EXEC)
//   trap        out  one-cycle pulse after a misaligned-target redirect
// ---------------------------------------------------------------------------
module sc_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        inst_valid,
    output logic        trap
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] pc4_w;
    logic [31:0] branch_off;
    logic [31:0] npc;
    logic [31:0] pc_advance;

    assign pc4_w = pc_reg + 32'd4;

    // Branch displacement is a signed word offset relative to pc + 4.
    assign branch_off = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};

    always_comb begin
        npc = pc4_w;
        case (pcsource)
            2'b00:   npc = pc4_w;
            2'b01:   npc = pc4_w + branch_off;
            2'b10:   npc = ra;
            default: npc = {pc4_w[31:28], inst_reg[25:0], 2'b00};
        endcase
    end

`ifdef SC_IFU_MISALIGN_TRAP_EN
    logic trap_reg, trap_next;
    logic misaligned;

    assign misaligned = (npc[1:0] != 2'b00);
    assign pc_advance = misaligned ? TRAP_PC : npc;
`else
    // Low bits are dropped silently; keep the otherwise unread bits visible
    // to lint as intentionally unused.
    logic unused_trap_bits;

    assign unused_trap_bits = ^{TRAP_PC, npc[1:0]};
    assign pc_advance       = {npc[31:2], 2'b00};
`endif

    // Next-state / next-data logic.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
`ifdef SC_IFU_MISALIGN_TRAP_EN
        trap_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    inst_next  = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // pcsource/ra are only sampled on the advancing cycle.
                if (!stall) begin
                    pc_next    = pc_advance;
                    state_next = FETCH;
`ifdef SC_IFU_MISALIGN_TRAP_EN
                    trap_next  = misaligned;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            inst_reg  <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
        end
    end

`ifdef SC_IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trap_reg <= 1'b0;
        end else begin
            trap_reg <= trap_next;
        end
    end

    assign trap = trap_reg;
`else
    assign trap = 1'b0;
`endif

    // Request and valid decode straight from the state register, so an
    // asynchronous reset drops them immediately.
    assign imem_req   = (state_reg == FETCH);
    assign inst_valid = (state_reg == EXEC);
    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign pc4        = pc4_w;
    assign inst       = inst_reg;

endmodule

// File: tb/tb_sc_ifu.sv
module tb_sc_ifu;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0080;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] ra = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        inst_valid;
    logic        trap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    item_t       sb[$];
    logic [31:0] model_pc;
    logic        trap_exp;

    sc_ifu #(
        .RESET_PC(RESET_PC),
        .TRAP_PC (TRAP_PC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pcsource  (pcsource),
        .ra        (ra),
        .stall     (stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst      (inst),
        .pc        (pc),
        .pc4       (pc4),
        .inst_valid(inst_valid),
        .trap      (trap)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next PC straight from the pcsource encoding.
    function automatic logic [31:0] calc_npc(input logic [31:0] cur_pc, input logic [31:0] iw,
                                             input logic [1:0] src, input logic [31:0] rav);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = cur_pc + 32'd4;
        off = {{14{iw[15]}}, iw[15:0], 2'b00};
        case (src)
            2'b00:   return p4;
            2'b01:   return p4 + off;
            2'b10:   return rav;
            default: return {p4[31:28], iw[25:0], 2'b00};
        endcase
    endfunction

    // Wait for the request, optionally withhold ack, then deliver word.
    task automatic do_fetch(input logic [31:0] word, input int delay);
        int n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, model_pc);
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clock);
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, model_pc);
            chk("wait_valid", {31'b0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back('{pc: model_pc, inst: word});
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Check the executing instruction against the scoreboard, optionally
    // stall, then advance with the given pcsource/ra.
    task automatic do_exec(input logic [1:0] src, input logic [31:0] rav, input int stalls);
        item_t       it;
        logic [31:0] npc;
        it = '{pc: model_pc, inst: 32'h0};
        chk("exec_valid", {31'b0, inst_valid}, 32'd1);
        chk("exec_trap_low", {31'b0, trap}, 32'd0);
        chk("sb_depth", sb.size(), 32'd1);
        if (sb.size() > 0) it = sb.pop_front();
        chk("exec_pc", pc, it.pc);
        chk("exec_inst", inst, it.inst);
        chk("exec_pc4", pc4, it.pc + 32'd4);
        for (int i = 0; i < stalls; i++) begin
            stall      = 1'b1;
            pcsource   = ~src;
            ra         = $urandom;
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            @(negedge clock);
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_pc", pc, it.pc);
            chk("stall_inst", inst, it.inst);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall    = 1'b0;
        imem_ack = 1'b0;
        pcsource = src;
        ra       = rav;
        npc      = calc_npc(it.pc, it.inst, src, rav);
`ifdef SC_IFU_MISALIGN_TRAP_EN
        if (npc[1:0] != 2'b00) begin
            model_pc = TRAP_PC;
            trap_exp = 1'b1;
        end else begin
            model_pc = npc;
            trap_exp = 1'b0;
        end
`else
        model_pc = {npc[31:2], 2'b00};
        trap_exp = 1'b0;
`endif
        @(negedge clock);
        pcsource = 2'($urandom);
        ra       = $urandom;
        chk("adv_pc", pc, model_pc);
        chk("adv_trap", {31'b0, trap}, {31'b0, trap_exp});
        chk("adv_valid", {31'b0, inst_valid}, 32'd0);
    endtask

    initial begin
        model_pc = RESET_PC;
        trap_exp = 1'b0;

        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("first_req", {31'b0, imem_req}, 32'd1);

        // First fetch and sequential advance.
        do_fetch(32'h2001_0005, 0);
        chk("first_inst", inst, 32'h2001_0005);
        do_exec(2'b00, 32'h0, 0);
        chk("first_next_pc", pc, 32'h0000_0004);

        // Branches around pc 0x10.
        do_fetch(32'h0000_0000, 0);
        do_exec(2'b10, 32'h0000_0010, 0);
        do_fetch(32'h1000_FFFE, 0);
        do_exec(2'b01, 32'h0, 0);
        chk("branch_back", pc, 32'h0000_000C);
        do_fetch(32'h0000_0000, 0);
        do_exec(2'b00, 32'h0, 0);
        do_fetch(32'h1000_0003, 0);
        do_exec(2'b01, 32'h0, 0);
        chk("branch_fwd", pc, 32'h0000_0020);

        // Jump and jr.
        do_fetch(32'h0000_0000, 0);
        do_exec(2'b10, 32'h1000_0040, 0);
        do_fetch(32'h0800_0100, 0);
        do_exec(2'b11, 32'h0, 0);
        chk("jump", pc, 32'h1000_0400);
        do_fetch(32'h0000_0008, 0);
        do_exec(2'b10, 32'h0000_0200, 0);
        chk("jr", pc, 32'h0000_0200);

        // Late ack and stall.
        do_fetch(32'h0123_4567, 5);
        do_exec(2'b00, 32'h0, 3);
        chk("stall_next_pc", pc, 32'h0000_0204);

        // Misaligned jr.
        do_fetch(32'h0000_0008, 0);
        do_exec(2'b10, 32'h0000_0102, 0);
`ifdef SC_IFU_MISALIGN_TRAP_EN
        chk("misalign_pc", pc, TRAP_PC);
`else
        chk("misalign_pc", pc, 32'h0000_0100);
`endif

        // Wraparound.
        do_fetch(32'h0000_0008, 0);
        do_exec(2'b10, 32'hFFFF_FFFC, 0);
        do_fetch(32'h0000_0000, 0);
        do_exec(2'b00, 32'h0, 0);
        chk("wrap", pc, 32'h0000_0000);

        // Reset mid-FETCH with an ack held during reset.
        do_fetch(32'h0000_0000, 0);
        do_exec(2'b10, 32'h0000_0300, 0);
        chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        reset      = 1'b1;
        #1;
        chk("rstf_req", {31'b0, imem_req}, 32'd0);
        chk("rstf_pc", pc, RESET_PC);
        @(negedge clock);
        chk("rstf_inst", inst, 32'h0);
        chk("rstf_valid", {31'b0, inst_valid}, 32'd0);
        reset    = 1'b0;
        imem_ack = 1'b0;
        model_pc = RESET_PC;

        // Reset mid-EXEC discards the pending jump.
        do_fetch(32'h0BAD_0040, 0);
        chk("pre_rste_valid", {31'b0, inst_valid}, 32'd1);
        pcsource = 2'b11;
        reset    = 1'b1;
        #1;
        chk("rste_pc", pc, RESET_PC);
        chk("rste_valid", {31'b0, inst_valid}, 32'd0);
        chk("rste_inst", inst, 32'h0);
        sb.delete();
        @(negedge clock);
        reset    = 1'b0;
        pcsource = 2'b00;
        model_pc = RESET_PC;

        // Resume cleanly from reset.
        do_fetch(32'h2001_0005, 0);
        do_exec(2'b00, 32'h0, 0);
        chk("resume_pc", pc, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
